// File: rtl/write_logic_counters_frm_pkg.sv
// Shared definitions for the packet-buffer write/read counters.
// Holds the frame FSM encoding and the default buffer geometry.
package write_logic_counters_frm_pkg;

    localparam int DEF_CHAR_WIDTH = 11;
    localparam int DEF_LINE_WIDTH = 3;
    localparam int MAX_LEN        = 1 << DEF_CHAR_WIDTH;
    localparam int NUM_LINES      = 1 << DEF_LINE_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DROP  = 2'd2
    } state_t;

endpackage

// File: rtl/write_logic_counters_frm_occ_counter.sv
// Up/down occupancy counter over 0..2^WIDTH lines.
// A decrement at zero and an increment at full are both ignored.
module write_logic_counters_frm_occ_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH:0]   occupancy,
    output logic             full,
    output logic             empty
);

    localparam logic [WIDTH:0] FULL_VAL = {1'b1, {WIDTH{1'b0}}};

    logic [WIDTH:0] occ_q;
    logic [WIDTH:0] occ_d;
    logic           dec_eff;
    logic           inc_eff;

    // An ignored decrement must not cancel a same-cycle increment.
    assign dec_eff = dec & (occ_q != '0);
    assign inc_eff = inc & ((occ_q != FULL_VAL) | dec_eff);

    always_comb begin
        occ_d = occ_q;
        case ({inc_eff, dec_eff})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
    assign full      = (occ_q == FULL_VAL);
    assign empty     = (occ_q == '0);

endmodule

// File: rtl/write_logic_counters_frm.sv
// Write-side pointer and frame commit/drop control for the line-organised
// packet buffer; each frame lands in one line or is discarded.
module write_logic_counters_frm
    import write_logic_counters_frm_pkg::*;
#(
    parameter int CHAR_WIDTH = DEF_CHAR_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_char_valid,
    input  logic                           wr_eof,
    input  logic                           wr_abort,
    input  logic                           rd_newline,
    output logic                           wr_en,
    output logic [LINE_WIDTH+CHAR_WIDTH-1:0] wr_ptr,
    output logic                           commit,
    output logic [CHAR_WIDTH:0]            commit_len,
    output logic                           drop,
    output logic [15:0]                    drop_cnt,
    output logic [LINE_WIDTH:0]            occupancy,
    output logic                           buf_full,
    output logic                           buf_empty
);

    localparam logic [CHAR_WIDTH:0] CNT_MAX = {1'b1, {CHAR_WIDTH{1'b0}}};

    state_t                  state_q, state_d;
    logic [CHAR_WIDTH:0]     cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic                    commit_q, commit_d;
    logic                    drop_q, drop_d;
    logic [CHAR_WIDTH:0]     commit_len_q, commit_len_d;
    logic [15:0]             drop_cnt_q, drop_cnt_d;
    logic                    acc;
    logic                    byte_in;

    assign byte_in = wr_char_valid & ~wr_abort;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        commit_d     = 1'b0;
        drop_d       = 1'b0;
        commit_len_d = commit_len_q;
        acc          = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Fullness is only judged at frame start; a started frame
                // always owns an uncommitted line.
                if (byte_in) begin
                    if (buf_full) begin
                        drop_d = 1'b1;
                        if (!wr_eof) state_d = S_DROP;
                    end else begin
                        acc = 1'b1;
                        if (!wr_eof) begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = S_WRITE;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (wr_abort) begin
                    cnt_d   = '0;
                    drop_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (wr_char_valid) begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        drop_d  = 1'b1;
                        state_d = wr_eof ? S_IDLE : S_DROP;
                    end else begin
                        acc = 1'b1;
                        if (!wr_eof) cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DROP: begin
                if ((wr_char_valid & wr_eof) | wr_abort) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (acc && wr_eof) begin
            commit_d     = 1'b1;
            commit_len_d = cnt_q + 1'b1;
            cnt_d        = '0;
            line_d       = line_q + 1'b1;
            state_d      = S_IDLE;
        end

        drop_cnt_d = drop_cnt_q;
        if (drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            commit_q     <= 1'b0;
            drop_q       <= 1'b0;
            commit_len_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            commit_q     <= commit_d;
            drop_q       <= drop_d;
            commit_len_q <= commit_len_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Occupancy moves in the same cycle the commit pulse becomes visible.
    write_logic_counters_frm_occ_counter #(
        .WIDTH (LINE_WIDTH)
    ) u_occ (
        .clk       (clk),
        .rst       (rst),
        .inc       (commit_d),
        .dec       (rd_newline),
        .occupancy (occupancy),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign wr_en      = acc;
    assign wr_ptr     = {line_q, cnt_q[CHAR_WIDTH-1:0]};
    assign commit     = commit_q;
    assign commit_len = commit_len_q;
    assign drop       = drop_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_write_logic_counters_frm.sv
// Directed bench for write_logic_counters_frm: a vector table for short
// sequences plus hand-written multi-cycle frame scenarios.
module tb_write_logic_counters_frm;

    localparam int CW = 11;
    localparam int LW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_char_valid = 1'b0;
    logic              wr_eof = 1'b0;
    logic              wr_abort = 1'b0;
    logic              rd_newline = 1'b0;
    logic              wr_en;
    logic [LW+CW-1:0]  wr_ptr;
    logic              commit;
    logic [CW:0]       commit_len;
    logic              drop;
    logic [15:0]       drop_cnt;
    logic [LW:0]       occupancy;
    logic              buf_full;
    logic              buf_empty;

    int errors = 0;
    int checks = 0;

    logic              s_en;
    logic [LW+CW-1:0]  s_ptr;

    always #5 clk = ~clk;

    write_logic_counters_frm #(.CHAR_WIDTH(CW), .LINE_WIDTH(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_char_valid (wr_char_valid),
        .wr_eof        (wr_eof),
        .wr_abort      (wr_abort),
        .rd_newline    (rd_newline),
        .wr_en         (wr_en),
        .wr_ptr        (wr_ptr),
        .commit        (commit),
        .commit_len    (commit_len),
        .drop          (drop),
        .drop_cnt      (drop_cnt),
        .occupancy     (occupancy),
        .buf_full      (buf_full),
        .buf_empty     (buf_empty)
    );

    typedef struct packed {
        logic        v, e, a, n;
        logic        en;
        logic [31:0] ptr;
        logic        cm, dr;
        logic [31:0] occ;
        logic [31:0] len;
    } vec_t;

    function automatic vec_t mk(input logic v, e, a, n, en, input int ptr,
                                input logic cm, dr, input int occ, len);
        vec_t r;
        r.v = v; r.e = e; r.a = a; r.n = n; r.en = en; r.ptr = ptr;
        r.cm = cm; r.dr = dr; r.occ = occ; r.len = len;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample the combinational write, then
    // return 1 time unit after the active edge for registered checks.
    task automatic step(input logic v, e, a, n);
        @(negedge clk);
        wr_char_valid = v; wr_eof = e; wr_abort = a; rd_newline = n;
        #1;
        s_en  = wr_en;
        s_ptr = wr_ptr;
        @(posedge clk);
        #1;
        wr_char_valid = 1'b0; wr_eof = 1'b0; wr_abort = 1'b0; rd_newline = 1'b0;
    endtask

    task automatic frame(input int len, input int line, input logic expw,
                         input logic eof_last, input logic nl_last);
        int bad;
        bad = 0;
        for (int i = 0; i < len; i++) begin
            step(1'b1, eof_last && (i == len - 1), 1'b0, nl_last && (i == len - 1));
            if (s_en !== expw) bad++;
            if (expw && (32'(s_ptr) != ((line << CW) | (i % (1 << CW))))) bad++;
        end
        check("frame_bytes_bad", bad, 0);
        $display("frame len=%0d line=%0d expect_write=%0d bad=%0d", len, line, expw, bad);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        wr_char_valid = 1'b0; wr_eof = 1'b0; wr_abort = 1'b0; rd_newline = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = mk(1,0,0,0, 1, 0,    0,0, 0, 0);
        tbl[1] = mk(1,0,0,0, 1, 1,    0,0, 0, 0);
        tbl[2] = mk(1,0,1,0, 0, 2,    0,1, 0, 0);
        tbl[3] = mk(1,1,0,0, 1, 0,    1,0, 1, 1);
        tbl[4] = mk(0,0,1,0, 0, 2048, 0,0, 1, 1);
        tbl[5] = mk(1,0,0,0, 1, 2048, 0,0, 1, 1);
        tbl[6] = mk(1,1,0,1, 1, 2049, 1,0, 1, 2);
        tbl[7] = mk(0,0,0,1, 0, 4096, 0,0, 0, 2);
        tbl[8] = mk(0,0,0,1, 0, 4096, 0,0, 0, 2);
        tbl[9] = mk(1,1,0,1, 1, 4096, 1,0, 1, 1);

        do_reset();
        check("rst_wr_ptr", wr_ptr, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_commit", commit, 0);
        check("rst_drop", drop, 0);
        check("rst_commit_len", commit_len, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_buf_empty", buf_empty, 1);
        check("rst_buf_full", buf_full, 0);
        check("rst_wr_en", wr_en, 0);

        for (int k = 0; k < 10; k++) begin
            step(tbl[k].v, tbl[k].e, tbl[k].a, tbl[k].n);
            $display("vec %0d: wr_en=%0d ptr=%0d commit=%0d drop=%0d occ=%0d len=%0d",
                     k, s_en, s_ptr, commit, drop, occupancy, commit_len);
            check("vec_wr_en", s_en, tbl[k].en);
            if (tbl[k].en) check("vec_wr_ptr", s_ptr, tbl[k].ptr);
            check("vec_commit", commit, tbl[k].cm);
            check("vec_drop", drop, tbl[k].dr);
            check("vec_occupancy", occupancy, tbl[k].occ);
            check("vec_commit_len", commit_len, tbl[k].len);
        end
        check("vec_drop_cnt", drop_cnt, 1);

        // Reset in the middle of a frame: silent discard.
        frame(3, 3, 1'b1, 1'b0, 1'b0);
        do_reset();
        check("midrst_drop", drop, 0);
        check("midrst_drop_cnt", drop_cnt, 0);
        check("midrst_wr_ptr", wr_ptr, 0);
        check("midrst_occupancy", occupancy, 0);

        // 64-byte frame.
        frame(64, 0, 1'b1, 1'b1, 1'b0);
        check("t1_commit", commit, 1);
        check("t1_commit_len", commit_len, 64);
        check("t1_wr_ptr", wr_ptr, 1 << CW);
        check("t1_occupancy", occupancy, 1);
        step(0, 0, 0, 0);
        check("t1_commit_pulse_end", commit, 0);

        // Abort after 10 bytes, then a 5-byte frame on the same line.
        do_reset();
        frame(10, 0, 1'b1, 1'b0, 1'b0);
        step(0, 0, 1, 0);
        $display("abort: drop=%0d drop_cnt=%0d ptr=%0d", drop, drop_cnt, wr_ptr);
        check("t2_drop", drop, 1);
        check("t2_drop_cnt", drop_cnt, 1);
        check("t2_wr_ptr", wr_ptr, 0);
        check("t2_commit", commit, 0);
        frame(5, 0, 1'b1, 1'b1, 1'b0);
        check("t2_commit", commit, 1);
        check("t2_commit_len", commit_len, 5);

        // Fill all 8 lines, then a frame against a full buffer.
        do_reset();
        for (int f = 0; f < 8; f++) frame(4, f, 1'b1, 1'b1, 1'b0);
        check("t3_occupancy", occupancy, 8);
        check("t3_buf_full", buf_full, 1);
        check("t3_wr_ptr_wrap", wr_ptr, 0);
        step(1, 0, 0, 0);
        check("t3_full_wr_en", s_en, 0);
        check("t3_full_drop", drop, 1);
        check("t3_full_drop_cnt", drop_cnt, 1);
        frame(3, 0, 1'b0, 1'b1, 1'b0);
        check("t3_no_second_drop", drop_cnt, 1);
        check("t3_no_commit", commit, 0);
        step(0, 0, 0, 1);
        check("t3_occ_after_read", occupancy, 7);
        frame(1, 0, 1'b1, 1'b1, 1'b0);
        check("t3_after_drop_commit", commit, 1);
        check("t3_after_drop_len", commit_len, 1);
        check("t3_refull", buf_full, 1);

        // Overflow: 2049 bytes without eof.
        do_reset();
        frame(2048, 0, 1'b1, 1'b0, 1'b0);
        check("t4_ptr_after_2048", wr_ptr, 0);
        check("t4_no_drop_yet", drop, 0);
        step(1, 0, 0, 0);
        $display("overflow: wr_en=%0d drop=%0d drop_cnt=%0d", s_en, drop, drop_cnt);
        check("t4_ovf_wr_en", s_en, 0);
        check("t4_ovf_drop", drop, 1);
        check("t4_ovf_drop_cnt", drop_cnt, 1);
        check("t4_ovf_wr_ptr", wr_ptr, 0);
        step(1, 0, 0, 0);
        check("t4_dropstate_wr_en", s_en, 0);
        check("t4_dropstate_drop", drop, 0);
        step(1, 1, 0, 0);
        check("t4_drop_exit_wr_en", s_en, 0);
        check("t4_drop_exit_commit", commit, 0);
        frame(3, 0, 1'b1, 1'b1, 1'b0);
        check("t4_next_commit_len", commit_len, 3);
        check("t4_next_wr_ptr", wr_ptr, 1 << CW);

        // Full-length 2048-byte frame.
        frame(2048, 1, 1'b1, 1'b1, 1'b0);
        check("t5_commit", commit, 1);
        check("t5_commit_len", commit_len, 2048);
        check("t5_wr_ptr", wr_ptr, 2 << CW);
        check("t5_drop", drop, 0);
        check("t5_drop_cnt", drop_cnt, 1);
        check("t5_occupancy", occupancy, 2);

        // Third commit, then commit and rd_newline together at occupancy 3.
        frame(2, 2, 1'b1, 1'b1, 1'b0);
        check("t6_occ3", occupancy, 3);
        frame(2, 3, 1'b1, 1'b1, 1'b1);
        check("t6_commit_and_read", occupancy, 3);
        check("t6_commit", commit, 1);
        for (int r = 0; r < 4; r++) begin
            step(0, 0, 0, 1);
            $display("newline %0d: occupancy=%0d", r, occupancy);
            check("t6_drain", occupancy, (r < 3) ? 2 - r : 0);
        end
        check("t6_buf_empty", buf_empty, 1);
        check("t6_buf_full", buf_full, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
